// File: rtl/instr_fetch_queue_pkg.sv
// rtl/instr_fetch_queue_pkg.sv - shared types and constants for the instruction fetch queue
//
// Purpose : default queue depth, the NOP word shown on an empty output,
//           the text-segment base address and the stored entry layout.
// Ports   : none (package).
package instr_fetch_queue_pkg;

   localparam int          IFQ_DEPTH_DEFAULT = 4;
   localparam logic [31:0] IFQ_NOP           = 32'h0000_0000;
   localparam logic [31:0] IFQ_TEXT_BASE     = 32'h0000_3000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifq_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - fetch-to-decode handshake bundle for the instruction fetch queue
//
// Purpose : groups the push side (fetch), pop side (decode), flush and
//           occupancy of the queue.
// Modports: master - fetch/decode side driving in_*, out_ready, flush
//           slave  - the queue itself
// Signals : in_valid/in_pc/in_instr/in_ready    push handshake
//           out_valid/out_pc/out_instr/out_ready pop handshake
//           flush                                discard all entries
//           count                                stored entries, $clog2(DEPTH)+1 bits
interface instr_fetch_queue_if #(
   parameter int DEPTH = 4
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic [31:0]   in_pc;
   logic [31:0]   in_instr;
   logic          in_ready;
   logic          out_valid;
   logic [31:0]   out_pc;
   logic [31:0]   out_instr;
   logic          out_ready;
   logic          flush;
   logic [CW-1:0] count;

   modport master (
      output in_valid, in_pc, in_instr, out_ready, flush,
      input  in_ready, out_valid, out_pc, out_instr, count
   );

   modport slave (
      input  in_valid, in_pc, in_instr, out_ready, flush,
      output in_ready, out_valid, out_pc, out_instr, count
   );

endinterface

// File: rtl/ifq_ram.sv
// rtl/ifq_ram.sv - DEPTH x 64-bit entry storage with read/write pointers
//
// Purpose : one synchronous write port at the write pointer, one
//           asynchronous read port at the read pointer. Pointers wrap
//           modulo DEPTH (DEPTH is a power of two, so plain overflow wraps).
// Ports   : clk, reset (sync, active-high), flush  - pointer clear
//           wr_en, wr_data                         - push at write pointer
//           rd_adv                                 - advance read pointer
//           rd_data                                - entry at read pointer
module ifq_ram
   import instr_fetch_queue_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       wr_en,
   input  ifq_entry_t wr_data,
   input  logic       rd_adv,
   output ifq_entry_t rd_data
);

   localparam int AW = $clog2(DEPTH);

   ifq_entry_t    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_d, wr_ptr_q;
   logic [AW-1:0] rd_ptr_d, rd_ptr_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(rd_adv);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is not reset; the caller never writes during reset or flush.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch queue between fetch and decode
//
// Purpose : FIFO of {pc, instr} entries. Push when in_valid & in_ready &
//           ~flush; pop when out_valid & out_ready. flush empties the queue
//           on the next edge while the current head stays visible and
//           consumable in the flush cycle. Empty output shows NOP.
// Ports   : clk, reset (sync, active-high), bus (instr_fetch_queue_if.slave)
// Config  : INSTR_FETCH_QUEUE_BYPASS_EN - when defined, an empty queue
//           forwards in_pc/in_instr to the output combinationally; if decode
//           takes it in that cycle it is never written.
module instr_fetch_queue
   import instr_fetch_queue_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   instr_fetch_queue_if.slave bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0] count_d, count_q;
   logic          empty;
   logic          full;
   logic          bypass;
   logic          push;
   logic          pop;
   ifq_entry_t    head;
   ifq_entry_t    wr_data;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
   assign bypass = empty & bus.in_valid & ~bus.flush & ~reset;
`else
   assign bypass = 1'b0;
`endif

   // in_ready looks only at stored occupancy, so out_ready never reaches it.
   assign bus.in_ready  = ~full;
   assign bus.out_valid = ~empty | bypass;
   assign bus.count     = count_q;

   // A bypassed instruction taken by decode this cycle is not stored.
   assign push = bus.in_valid & ~full & ~bus.flush & ~reset & ~(bypass & bus.out_ready);
   assign pop  = ~empty & bus.out_ready & ~reset;

   assign wr_data.pc    = bus.in_pc;
   assign wr_data.instr = bus.in_instr;

   assign bus.out_pc    = ~empty ? head.pc    : (bypass ? bus.in_pc    : IFQ_NOP);
   assign bus.out_instr = ~empty ? head.instr : (bypass ? bus.in_instr : IFQ_NOP);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (bus.flush) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   ifq_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .flush   (bus.flush),
      .wr_en   (push),
      .wr_data (wr_data),
      .rd_adv  (pop),
      .rd_data (head)
   );

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, the number of queue entries (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the fetch stage presents an instruction.
REQ-005 The block SHALL have port in_pc, input, 32 bits: the PC of the presented instruction.
REQ-006 The block SHALL have port in_instr, input, 32 bits: the instruction word fetched at in_pc.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the queue accepts a push this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the head entry is presented to decode.
REQ-009 The block SHALL have port out_pc, output, 32 bits: the PC of the head entry.
REQ-010 The block SHALL have port out_instr, output, 32 bits: the instruction word of the head entry.
REQ-011 The block SHALL have port out_ready, input, 1 bit: decode consumes the head this cycle.
REQ-012 The block SHALL have port flush, input, 1 bit: discard all entries (branch/jump redirect).
REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of stored entries.

Function
REQ-014 A push SHALL occur when in_valid and in_ready are both 1 and flush is 0; {in_pc, in_instr} is written at the write pointer.
REQ-015 A pop SHALL occur when out_valid and out_ready are both 1; the read pointer then advances.
REQ-016 in_ready SHALL be 1 exactly when count < DEPTH; a same-cycle pop SHALL NOT raise in_ready, so there is no combinational path from out_ready to in_ready.
REQ-017 out_valid SHALL be 1 when count > 0.
REQ-018 While out_valid is 1, out_pc and out_instr SHALL equal the head entry.
REQ-019 While out_valid is 0, out_pc SHALL be 32'h0 and out_instr SHALL be 32'h0 (NOP).
REQ-020 The latency from push to out_valid SHALL be 1 cycle when the queue is empty.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-023 A push while full SHALL be impossible; in_valid held while in_ready is 0 SHALL change no state.
REQ-024 A pop while empty SHALL be impossible; out_ready while out_valid is 0 SHALL be ignored.
REQ-025 When flush is 1, the next state SHALL be empty: both pointers 0 and count 0; any push in that cycle SHALL be dropped.
REQ-026 When flush is 1, the outputs in that cycle SHALL still reflect the current head, and decode may consume it.
REQ-027 Entries SHALL carry no check of in_pc alignment; PC values pass through unmodified.

Reset
REQ-028 While reset is 1, the next state SHALL be empty: pointers 0 and count 0; reset SHALL have priority over flush, push and pop.
REQ-029 Reset values SHALL be: in_ready 1, out_valid 0, out_pc 0, out_instr 0, count 0; storage contents are don't-care.
REQ-030 A reset asserted mid-stream SHALL discard all entries, exactly as flush does.

Configuration
REQ-031 When macro INSTR_FETCH_QUEUE_BYPASS_EN is defined, an empty queue with in_valid 1 and flush 0 SHALL drive out_valid 1 with out_pc = in_pc and out_instr = in_instr combinationally.
REQ-032 In that bypass case, if out_ready is 1 the instruction SHALL be consumed and not written; otherwise it SHALL be pushed normally.
REQ-033 When INSTR_FETCH_QUEUE_BYPASS_EN is undefined, no bypass path SHALL exist and REQ-020 latency applies.

Structure
REQ-034 A shared package SHALL hold: DEPTH default, the NOP value 32'h0, the text-segment base 32'h0000_3000, and the entry struct {pc[31:0], instr[31:0]}.
REQ-035 The storage array and its pointers SHALL be a sub-module named ifq_ram: DEPTH x 64 bits, 1 synchronous write port, 1 asynchronous read port.

Verification
REQ-036 Reset, then push pc=0x3000 instr=0x3C010001 -> next cycle out_valid=1, out_pc=0x3000, out_instr=0x3C010001, count=1.
REQ-037 Push 4 entries (pc 0x3000..0x300C) with out_ready=0 -> in_ready=0, count=4; a 5th in_valid is dropped; then 4 pops return pcs 0x3000, 0x3004, 0x3008, 0x300C in order.
REQ-038 Hold count=2 with simultaneous push/pop for 10 cycles -> count stays 2, out_pc increments by 4 each cycle, pointers wrap correctly.
REQ-039 count=3, flush=1 with in_valid=1 -> outputs still show head that cycle, next cycle count=0, out_valid=0, out_instr=0; pushed entry absent.
REQ-040 Reset asserted with count=2 and push/pop active -> next cycle count=0, in_ready=1, out_valid=0.
REQ-041 With INSTR_FETCH_QUEUE_BYPASS_EN defined: queue empty, in_valid=1, out_ready=1, pc=0x3010 -> same cycle out_valid=1, out_pc=0x3010; next cycle count=0.
